// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-back types used by the
// write-back scheduler and its arbiter.
package regfile_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found after
// the last granted index; the pointer moves only when advance is high.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    cand   = '0;
    last_d = last_q;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
        last_d      = cand;
      end
    end
  end

  // Reset pointer to N-1 so that source 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= IW'(N - 1);
    end else if (advance) begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-back scheduler: arbitrates sources onto the single
// write port and tracks pending destinations for decode hazard stalls.
module regfile_wb_sched #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [XLEN-1:0]           wr_data,
  output logic                      write_en,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      hazard,
  output logic                      wb_unexpected
);
  import regfile_pkg::*;

  localparam int NREG = 1 << ADDR_W;

  // Handshake: source i transfers on a cycle where src_valid[i] & src_ready[i];
  // it holds addr/data until then and may drop valid early (losing its turn).
  logic [NUM_SRC-1:0] grant;
  logic               transfer;
  logic [ADDR_W-1:0]  win_addr;
  logic [XLEN-1:0]    win_data;

  logic [ADDR_W-1:0]  wr_addr_q;
  logic [XLEN-1:0]    wr_data_q;
  logic               write_en_q;
  logic               unexp_q;
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_d;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (src_valid),
    .advance (transfer),
    .grant   (grant)
  );

  assign src_ready = grant;
  assign transfer  = |(src_valid & grant);

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        win_addr = src_addr[i*ADDR_W +: ADDR_W];
        win_data = src_data[i*XLEN +: XLEN];
      end
    end
  end

  // Set after clear: a newly issued producer outranks the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (write_en_q) busy_d[wr_addr_q] = 1'b0;
    if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      write_en_q <= 1'b0;
      unexp_q    <= 1'b0;
      busy_q     <= '0;
    end else begin
      write_en_q <= transfer && (win_addr != '0);
      if (transfer) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
      if (transfer && win_addr != '0 && !busy_q[win_addr]) unexp_q <= 1'b1;
      busy_q <= busy_d;
    end
  end

  // The write cycle itself is forwarded by the register file, so not a stall.
  assign hazard = (busy_q[rs1_addr] && !(write_en_q && wr_addr_q == rs1_addr)) ||
                  (busy_q[rs2_addr] && !(write_en_q && wr_addr_q == rs2_addr));

  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign write_en      = write_en_q;
  assign wb_unexpected = unexp_q;
endmodule
